// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcodes and IR field layout.
// Datapath blocks and benches import this so encodings stay in one place.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD       = 5'd3;
  localparam logic [4:0] OP_SUB       = 5'd4;
  localparam logic [4:0] OP_ALU_FIRST = 5'd3;
  localparam logic [4:0] OP_ALU_LAST  = 5'd14;
  localparam logic [4:0] OP_MUL       = 5'd15;
  localparam logic [4:0] OP_DIV       = 5'd16;
  localparam logic [4:0] OP_HALT      = 5'd27;

  // MSB position of each IR field; widths are fixed below.
  localparam int OP_MSB = 31;
  localparam int RA_MSB = 26;
  localparam int RB_MSB = 22;
  localparam int RC_MSB = 18;
  localparam int OP_W   = 5;
  localparam int REG_W  = 4;
  localparam int NUM_REGS = 1 << REG_W;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_sequencer_onehot_decode.sv
// Index to one-hot decoder with enable; output is all-zero when disabled,
// so at most one bit is ever set.
module onehot_decode #(
  parameter int IDX_W = 4
) (
  input  logic                     en,
  input  logic [IDX_W-1:0]         idx,
  output logic [(1<<IDX_W)-1:0]    onehot
);

  for (genvar i = 0; i < (1 << IDX_W); i++) begin : g_bit
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction fetch/execute control sequencer. Strobes are decoded from the
// current state (and IR in T3-T6 only); MDRIn additionally follows memReady in T1.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        memReady,
  output logic [15:0] regIn,
  output logic [15:0] regOut,
  output logic        HiIn,
  output logic        LoIn,
  output logic        ZIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        YIn,
  output logic        MARIn,
  output logic        IRIn,
  output logic        IncPC,
  output logic        HiOut,
  output logic        LoOut,
  output logic        ZHiOut,
  output logic        ZLoOut,
  output logic        PCOut,
  output logic        MDROut,
  output logic        MDRread,
  output logic [4:0]  ALUcode,
  output logic        halted,
  output logic [3:0]  state
);

  state_t           cur;
  logic             t1_first;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] ra, rb, rc;
  logic             is_alu, is_muldiv, is_exec;
  state_t           done_state;
  logic             ri_en, ro_en;
  logic [REG_W-1:0] ro_idx;
  logic             unused_ir;

  assign op        = IR[OP_MSB -: OP_W];
  assign ra        = IR[RA_MSB -: REG_W];
  assign rb        = IR[RB_MSB -: REG_W];
  assign rc        = IR[RC_MSB -: REG_W];
  assign unused_ir = ^IR[RC_MSB-REG_W:0];
  assign is_alu    = is_alu_op(op);
  assign is_muldiv = is_muldiv_op(op);
  assign is_exec   = is_alu || is_muldiv;

  // An instruction always completes; run only decides where the next one starts.
  assign done_state = run ? ST_T0 : ST_IDLE;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur      <= ST_IDLE;
      t1_first <= 1'b0;
    end else begin
      case (cur)
        ST_IDLE: if (run) cur <= ST_T0;
        ST_T0: begin
          cur      <= ST_T1;
          t1_first <= 1'b1;
        end
        ST_T1: begin
          t1_first <= 1'b0;
          if (memReady) cur <= ST_T2;
        end
        ST_T2: cur <= ST_T3;
        ST_T3: begin
          if (is_exec)             cur <= ST_T4;
          else if (op == OP_HALT)  cur <= ST_HALT;
          else                     cur <= done_state;
        end
        ST_T4:   cur <= ST_T5;
        ST_T5:   cur <= is_muldiv ? ST_T6 : done_state;
        ST_T6:   cur <= done_state;
        ST_HALT: cur <= ST_HALT;
        default: cur <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ri_en   = 1'b0;
    ro_en   = 1'b0;
    ro_idx  = rb;
    HiIn    = 1'b0;
    LoIn    = 1'b0;
    ZIn     = 1'b0;
    PCIn    = 1'b0;
    MDRIn   = 1'b0;
    YIn     = 1'b0;
    MARIn   = 1'b0;
    IRIn    = 1'b0;
    IncPC   = 1'b0;
    HiOut   = 1'b0;
    LoOut   = 1'b0;
    ZHiOut  = 1'b0;
    ZLoOut  = 1'b0;
    PCOut   = 1'b0;
    MDROut  = 1'b0;
    MDRread = 1'b0;
    ALUcode = 5'd0;
    case (cur)
      ST_T0: begin
        PCOut = 1'b1;
        MARIn = 1'b1;
        IncPC = 1'b1;
        ZIn   = 1'b1;
      end
      ST_T1: begin
        ZLoOut  = 1'b1;
        MDRread = 1'b1;
        PCIn    = t1_first;
        MDRIn   = memReady;
      end
      ST_T2: begin
        MDROut = 1'b1;
        IRIn   = 1'b1;
      end
      ST_T3: begin
        ro_en = is_exec;
        YIn   = is_exec;
      end
      ST_T4: begin
        ro_en   = 1'b1;
        ro_idx  = rc;
        ZIn     = 1'b1;
        ALUcode = op;
      end
      ST_T5: begin
        ZLoOut = 1'b1;
        LoIn   = is_muldiv;
        ri_en  = is_alu;
      end
      ST_T6: begin
        ZHiOut = 1'b1;
        HiIn   = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_decode #(.IDX_W(REG_W)) u_reg_in (
    .en     (ri_en),
    .idx    (ra),
    .onehot (regIn)
  );

  onehot_decode #(.IDX_W(REG_W)) u_reg_out (
    .en     (ro_en),
    .idx    (ro_idx),
    .onehot (regOut)
  );

  assign halted = (cur == ST_HALT);
  assign state  = cur;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each driven cycle pushes the expected output vector,
// a negedge monitor pops and compares it against the DUT.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic        clock, clear, run, memReady;
  logic [31:0] IR;
  logic [15:0] regIn, regOut;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn, IncPC;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, MDRread;
  logic [4:0]  ALUcode;
  logic        halted;
  logic [3:0]  state;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR), .memReady(memReady),
    .regIn(regIn), .regOut(regOut),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .YIn(YIn),
    .MARIn(MARIn), .IRIn(IRIn), .IncPC(IncPC),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
    .PCOut(PCOut), .MDROut(MDROut), .MDRread(MDRread),
    .ALUcode(ALUcode), .halted(halted), .state(state)
  );

  localparam logic [15:0] S_HIIN = 16'h8000, S_LOIN = 16'h4000, S_ZIN = 16'h2000, S_PCIN = 16'h1000;
  localparam logic [15:0] S_MDRIN = 16'h0800, S_YIN = 16'h0400, S_MARIN = 16'h0200, S_IRIN = 16'h0100;
  localparam logic [15:0] S_INCPC = 16'h0080, S_HIOUT = 16'h0040, S_LOOUT = 16'h0020, S_ZHIOUT = 16'h0010;
  localparam logic [15:0] S_ZLOOUT = 16'h0008, S_PCOUT = 16'h0004, S_MDROUT = 16'h0002, S_MDRREAD = 16'h0001;

  localparam logic [31:0] ADD_IR = 32'h1A1B8000;

  logic [15:0] strobes;
  logic [63:0] obs;
  assign strobes = {HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn, IncPC,
                    HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, MDRread};
  assign obs = {6'd0, halted, state, regIn, regOut, strobes, ALUcode};

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input logic [3:0] st, input logic [15:0] ri,
                                     input logic [15:0] ro, input logic [15:0] sv,
                                     input logic [4:0] alu);
    return {6'd0, (st == 4'd8), st, ri, ro, sv, alu};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    return 16'h0001 << i;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    n_cyc <= n_cyc + 1;
    if (sb.size() > 0) chk($sformatf("cyc%0d", n_cyc), obs, sb.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input logic r, input logic m, input logic [31:0] ir, input logic [63:0] e);
    @(posedge clock);
    #1;
    run = r;
    memReady = m;
    IR = ir;
    sb.push_back(e);
  endtask

  // T0..T2 with IR scrambled until the load cycle; it must not affect strobes there.
  task automatic fetch(input logic [31:0] ir, input int stall);
    cyc(1'b1, 1'b0, $urandom, ev(ST_T0, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'd0));
    for (int i = 0; i < stall; i++)
      cyc(1'b1, 1'b0, $urandom, ev(ST_T1, 16'h0, 16'h0, S_ZLOOUT | S_MDRREAD | ((i == 0) ? S_PCIN : 16'h0), 5'd0));
    cyc(1'b1, 1'b1, $urandom,
        ev(ST_T1, 16'h0, 16'h0, S_ZLOOUT | S_MDRREAD | S_MDRIN | ((stall == 0) ? S_PCIN : 16'h0), 5'd0));
    cyc(1'b1, 1'b0, ir, ev(ST_T2, 16'h0, 16'h0, S_MDROUT | S_IRIN, 5'd0));
  endtask

  task automatic exec(input logic [31:0] ir, input logic r);
    logic [4:0] op;
    op = ir[31:27];
    if ((op >= 5'd3 && op <= 5'd14) || op == 5'd15 || op == 5'd16) begin
      cyc(r, 1'b0, ir, ev(ST_T3, 16'h0, oh(ir[22:19]), S_YIN, 5'd0));
      cyc(r, 1'b0, ir, ev(ST_T4, 16'h0, oh(ir[18:15]), S_ZIN, op));
      if (op == 5'd15 || op == 5'd16) begin
        cyc(r, 1'b0, ir, ev(ST_T5, 16'h0, 16'h0, S_ZLOOUT | S_LOIN, 5'd0));
        cyc(r, 1'b0, ir, ev(ST_T6, 16'h0, 16'h0, S_ZHIOUT | S_HIIN, 5'd0));
      end else begin
        cyc(r, 1'b0, ir, ev(ST_T5, oh(ir[26:23]), 16'h0, S_ZLOOUT, 5'd0));
      end
    end else begin
      cyc(r, 1'b0, ir, ev(ST_T3, 16'h0, 16'h0, 16'h0, 5'd0));
    end
  endtask

  initial begin
    logic [31:0] ir_c;
    clear = 1'b0;
    run = 1'b1;
    memReady = 1'b0;
    IR = 32'h0;

    // held in reset with run high: must stay idle
    repeat (3) cyc(1'b1, 1'b0, 32'h0, ev(ST_IDLE, 16'h0, 16'h0, 16'h0, 5'd0));
    clear = 1'b1;

    // add R4,R3,R7 with literal expectations
    fetch(ADD_IR, 0);
    cyc(1'b1, 1'b0, ADD_IR, ev(ST_T3, 16'h0, 16'h0008, S_YIN, 5'd0));
    cyc(1'b1, 1'b0, ADD_IR, ev(ST_T4, 16'h0, 16'h0080, S_ZIN, 5'd3));
    cyc(1'b1, 1'b0, ADD_IR, ev(ST_T5, 16'h0010, 16'h0, S_ZLOOUT, 5'd0));

    // mul R0,R5,R6 with a 3-cycle memory stall, then div, then a no-op
    fetch({OP_MUL, 4'd0, 4'd5, 4'd6, 15'h0}, 3);
    exec({OP_MUL, 4'd0, 4'd5, 4'd6, 15'h0}, 1'b1);
    fetch({OP_DIV, 4'd2, 4'd12, 4'd1, 15'h7FFF}, 1);
    exec({OP_DIV, 4'd2, 4'd12, 4'd1, 15'h7FFF}, 1'b1);
    fetch({5'd20, 4'd1, 4'd2, 4'd3, 15'h0}, 0);
    exec({5'd20, 4'd1, 4'd2, 4'd3, 15'h0}, 1'b1);

    // run dropped from T3 on: instruction completes, then idle
    fetch({OP_SUB, 4'd9, 4'd10, 4'd11, 15'h1234}, 0);
    exec({OP_SUB, 4'd9, 4'd10, 4'd11, 15'h1234}, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 32'h0, ev(ST_IDLE, 16'h0, 16'h0, 16'h0, 5'd0));
    cyc(1'b1, 1'b0, 32'h0, ev(ST_IDLE, 16'h0, 16'h0, 16'h0, 5'd0));

    // asynchronous clear in the middle of T4
    ir_c = {OP_ADD, 4'd15, 4'd14, 4'd13, 15'h0};
    fetch(ir_c, 0);
    cyc(1'b1, 1'b0, ir_c, ev(ST_T3, 16'h0, oh(4'd14), S_YIN, 5'd0));
    @(posedge clock);
    #1;
    chk("t4_before_clear", {43'd0, state, ZIn, regOut}, {43'd0, 4'd5, 1'b1, 16'h2000});
    sb.push_back(ev(ST_IDLE, 16'h0, 16'h0, 16'h0, 5'd0));
    #1 clear = 1'b0;
    cyc(1'b1, 1'b0, ir_c, ev(ST_IDLE, 16'h0, 16'h0, 16'h0, 5'd0));
    clear = 1'b1;

    // halt: no T3 strobes, then absorbing HALT regardless of run
    fetch({OP_HALT, 4'd3, 4'd4, 4'd5, 15'h0}, 2);
    exec({OP_HALT, 4'd3, 4'd4, 4'd5, 15'h0}, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(((i % 2) == 0), 1'b1, $urandom, ev(ST_HALT, 16'h0, 16'h0, 16'h0, 5'd0));

    @(posedge clock);
    #1 clear = 1'b0;
    repeat (2) @(negedge clock);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: run  in  1  high = sequencer may leave IDLE/continue; low = stop at next T0 boundary.
REQ-004 SHALL have port: IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 SHALL have port: memReady  in  1  memory read data valid on Mdata this cycle.
REQ-006 SHALL have ports: regIn, regOut  out  16 each  one-hot register file enables.
REQ-007 SHALL have ports: HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn, IncPC  out  1 each  datapath load/increment strobes.
REQ-008 SHALL have ports: HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut  out  1 each  bus drive selects.
REQ-009 SHALL have port: MDRread  out  1  MDR input mux selects memory data and memory read is requested.
REQ-010 SHALL have port: ALUcode  out  5  ALU operation; equals IR[31:27] when asserted.
REQ-011 SHALL have ports: halted  out  1; state  out  4  current state for debug.

Function
REQ-012 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, one transition per clock edge unless stalled.
REQ-013 IDLE SHALL go to T0 when run=1 and stay in IDLE otherwise.
REQ-014 T0 SHALL assert PCOut, MARIn, IncPC, ZIn.
REQ-015 T1 SHALL assert ZLoOut, PCIn, MDRread; MDRIn SHALL be asserted only while memReady=1; T1 SHALL hold (PCIn only in first T1 cycle) until memReady=1, then go to T2.
REQ-016 T2 SHALL assert MDROut, IRIn, then go to T3.
REQ-017 T3 SHALL assert regOut[Rb], YIn.
REQ-018 T4 SHALL assert regOut[Rc], ZIn, ALUcode=IR[31:27].
REQ-019 For ALU opcodes 5'd3-5'd14, T5 SHALL assert ZLoOut, regIn[Ra], then go to T0 (run=1) or IDLE (run=0).
REQ-020 For mul (5'd15) and div (5'd16), T5 SHALL assert ZLoOut, LoIn; T6 SHALL assert ZHiOut, HiIn; then T0/IDLE as in REQ-019.
REQ-021 halt (5'd27) SHALL go from T3 to HALT with no T3 strobes; HALT is absorbing, halted=1, until reset.
REQ-022 Any other opcode SHALL be a no-op: T3 goes directly to T0/IDLE, no strobes asserted in T3.
REQ-023 Outputs SHALL be combinational functions of state and IR only (Moore per state); at most one bus driver asserted per cycle.
REQ-024 ALUcode SHALL be 5'd0 in all states other than T4.
REQ-025 Register index 4 bits SHALL map directly to one-hot bit; regIn/regOut SHALL never have more than one bit set.
REQ-026 run falling mid-instruction SHALL not abort; the instruction completes and the sequencer then enters IDLE.
REQ-027 IR SHALL be sampled only in T3-T6; changes during T0-T2 SHALL have no effect on strobes.

Reset
REQ-028 clear=0 SHALL immediately force state=IDLE and all outputs to 0, including mid-T1 stall.
REQ-029 After clear rises, first possible transition SHALL be IDLE->T0 on the next clock edge with run=1.

Structure
REQ-030 State encodings, opcode constants (ADD=5'd3, SUB=5'd4, MUL=5'd15, DIV=5'd16, HALT=5'd27) and IR field positions SHALL live in a shared package used by the datapath and benches.
REQ-031 A sub-module onehot_decode (4-bit index to 16-bit one-hot, with enable) SHALL be instantiated for regIn and regOut.

Verification
REQ-032 add R4,R3,R7 (IR=32'h1A1B8000), memReady=1 in T1 -> T3 regOut=16'h0008,YIn; T4 regOut=16'h0080,ZIn,ALUcode=5'd3; T5 regIn=16'h0010,ZLoOut.
REQ-033 mul R0,R5,R6 (opcode 15) -> T5 ZLoOut+LoIn, T6 ZHiOut+HiIn, regIn=0 throughout, back to T0.
REQ-034 memReady held low 3 cycles in T1 -> state stays T1 4 cycles, PCIn high only first cycle, MDRIn high only in final cycle.
REQ-035 halt opcode 27 -> HALT after T3, halted=1, all strobes 0 for 10 further cycles regardless of run.
REQ-036 clear=0 asynchronously during T4 -> state=IDLE and ZIn/regOut=0 before next edge; resumes T0 after release with run=1.
REQ-037 run dropped during T3 of add -> T4, T5 complete, then IDLE; no T0 strobes.
